// File: rtl/axi_burst_pkg.sv
// +----------------------------------------------------------------------------+
// | axi_burst_pkg : shared state, AXI field and status encodings               |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package axi_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_AR   = 3'd2,
    ST_R    = 3'd3,
    ST_AW   = 3'd4,
    ST_W    = 3'd5,
    ST_B    = 3'd6,
    ST_STS  = 3'd7
  } state_e;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] STS_OK      = 2'd0;
  localparam logic [1:0] STS_SLVERR  = 2'd1;
  localparam logic [1:0] STS_LASTERR = 2'd2;
  localparam logic [1:0] STS_ILLEGAL = 2'd3;

endpackage

`default_nettype wire

// File: rtl/axi_burst_master_if.sv
// +----------------------------------------------------------------------------+
// | axi_burst_master_if : command/stream/status plus AXI4 master bundle        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface axi_burst_master_if #(
  parameter int ADDR_W = 32
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;

  logic              rd_valid;
  logic              rd_ready;
  logic [31:0]       rd_data;
  logic              rd_last;

  logic              sts_valid;
  logic              sts_ready;
  logic              sts_err;
  logic [1:0]        sts_code;

  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;

  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;

  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic [1:0]        m_axi_bresp;

  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;

  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic              m_axi_rlast;
  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data, wr_strb,
    output wr_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    output sts_valid, sts_err, sts_code,
    input  sts_ready,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp,
    output m_axi_bready,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rlast, m_axi_rdata, m_axi_rresp,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data, wr_strb,
    input  wr_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    input  sts_valid, sts_err, sts_code,
    output sts_ready,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp,
    input  m_axi_bready,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rlast, m_axi_rdata, m_axi_rresp,
    input  m_axi_rready
  );

endinterface

`default_nettype wire

// File: rtl/axi_burst_chk.sv
// +----------------------------------------------------------------------------+
// | axi_burst_chk : combinational legality check of a latched burst command    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_burst_chk #(
  parameter int MAX_LEN = 15
) (
  input  wire logic [11:0] addr_i,
  input  wire logic [7:0]  len_i,
  output logic             illegal_o
);

  logic [13:0] page_end;

  // Byte offset one past the last beat; 14 bits hold 4095 + 256*4 without overflow.
  assign page_end = {2'b00, addr_i} + {4'b0000, len_i, 2'b00} + 14'd4;

  assign illegal_o = (addr_i[1:0] != 2'b00)
                   || (32'(len_i) > 32'(MAX_LEN))
                   || (page_end > 14'd4096);

endmodule

`default_nettype wire

// File: rtl/axi_burst_master.sv
// +----------------------------------------------------------------------------+
// | axi_burst_master : one command in, one AXI4 INCR burst out, one status back|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MAX_LEN = 15
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  axi_burst_master_if.master     bus
);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [7:0]        len_q,   len_d;
  logic [8:0]        beat_q,  beat_d;
  logic [1:0]        code_q,  code_d;
  logic              illegal;
  logic              last_beat;

  axi_burst_chk #(
    .MAX_LEN (MAX_LEN)
  ) u_chk (
    .addr_i    (addr_q[11:0]),
    .len_i     (len_q),
    .illegal_o (illegal)
  );

  assign last_beat = (beat_q == {1'b0, len_q});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      code_q  <= STS_OK;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          write_d = bus.cmd_write;
          addr_d  = bus.cmd_addr;
          len_d   = bus.cmd_len;
          code_d  = STS_OK;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (illegal) begin
          code_d  = STS_ILLEGAL;
          state_d = ST_STS;
        end else begin
          state_d = write_q ? ST_AW : ST_AR;
        end
      end
      ST_AR: begin
        if (bus.m_axi_arready) begin
          beat_d  = '0;
          state_d = ST_R;
        end
      end
      ST_R: begin
        if (bus.m_axi_rvalid && bus.rd_ready) begin
          beat_d = beat_q + 9'd1;
          // A slave error outranks a framing error and is never downgraded.
          if (bus.m_axi_rresp != 2'b00) begin
            code_d = STS_SLVERR;
          end else if ((code_q == STS_OK) && (bus.m_axi_rlast != last_beat)) begin
            code_d = STS_LASTERR;
          end
          if (bus.m_axi_rlast) begin
            state_d = ST_STS;
          end
        end
      end
      ST_AW: begin
        if (bus.m_axi_awready) begin
          beat_d  = '0;
          state_d = ST_W;
        end
      end
      ST_W: begin
        if (bus.wr_valid && bus.m_axi_wready) begin
          beat_d = beat_q + 9'd1;
          if (last_beat) begin
            state_d = ST_B;
          end
        end
      end
      ST_B: begin
        if (bus.m_axi_bvalid) begin
          if (bus.m_axi_bresp != 2'b00) begin
            code_d = STS_SLVERR;
          end
          state_d = ST_STS;
        end
      end
      ST_STS: begin
        if (bus.sts_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready     = 1'b0;
    bus.m_axi_arvalid = 1'b0;
    bus.m_axi_rready  = 1'b0;
    bus.rd_valid      = 1'b0;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wvalid  = 1'b0;
    bus.wr_ready      = 1'b0;
    bus.m_axi_bready  = 1'b0;
    bus.sts_valid     = 1'b0;
    bus.sts_err       = 1'b0;
    bus.sts_code      = STS_OK;
    unique case (state_q)
      // Held low while reset is asserted so the port reads idle during reset.
      ST_IDLE: bus.cmd_ready = ~rst_i;
      ST_AR:   bus.m_axi_arvalid = 1'b1;
      ST_R: begin
        bus.m_axi_rready = bus.rd_ready;
        bus.rd_valid     = bus.m_axi_rvalid;
      end
      ST_AW:   bus.m_axi_awvalid = 1'b1;
      ST_W: begin
        bus.m_axi_wvalid = bus.wr_valid;
        bus.wr_ready     = bus.m_axi_wready;
      end
      ST_B:    bus.m_axi_bready = 1'b1;
      ST_STS: begin
        bus.sts_valid = 1'b1;
        bus.sts_err   = (code_q != STS_OK);
        bus.sts_code  = code_q;
      end
      default: ;
    endcase
  end

  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = len_q;
  assign bus.m_axi_arsize  = AXI_SIZE_4B;
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = len_q;
  assign bus.m_axi_awsize  = AXI_SIZE_4B;
  assign bus.m_axi_awburst = AXI_BURST_INCR;
  assign bus.m_axi_wdata   = bus.wr_data;
  assign bus.m_axi_wstrb   = bus.wr_strb;
  assign bus.rd_data       = bus.m_axi_rdata;
  assign bus.rd_last       = bus.m_axi_rlast;

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_master.sv
// +----------------------------------------------------------------------------+
// | tb_axi_burst_master : memory responder, reference model and checker        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_axi_burst_master;
  import axi_burst_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_burst_master_if #(.ADDR_W(32)) bus ();

  axi_burst_master #(.ADDR_W(32), .MAX_LEN(15)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed { logic [31:0] d; logic [3:0] s; } wbeat_t;
  typedef struct packed { logic [31:0] d; logic l; } rexp_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem       [0:1023];
  logic [31:0] model_mem [0:1023];
  wbeat_t      wq[$];
  rexp_t       exp_rd[$];
  logic [2:0]  exp_sts[$];
  logic [31:0] rd_log[$];

  logic        cur_illegal = 1'b0;
  logic [31:0] cur_addr    = '0;
  logic [7:0]  cur_len     = '0;
  logic [1:0]  k_bresp     = 2'b00;
  int          k_rerr_beat = -1;
  int          k_rlast_beat = -1;
  logic        k_toggle    = 1'b0;

  int          sts_seen   = 0;
  logic [1:0]  last_code  = '0;
  logic        last_err   = 1'b0;
  int          w_accepted = 0;
  int          addr_fires = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- AXI memory responder and stream sources ----------------
  logic        r_act, aw_done, b_pend;
  int          r_beat, r_len, w_cnt, w_len;
  logic [9:0]  r_idx, w_idx;
  logic        f_ar, f_aw, f_r, f_w, f_b, f_wr;
  logic [31:0] f_wdata;
  logic [3:0]  f_wstrb;
  logic [31:0] f_araddr, f_awaddr;
  logic [7:0]  f_arlen, f_awlen;
  logic        f_rlast;

  initial begin : responder
    r_act = 0; aw_done = 0; b_pend = 0; r_beat = 0; r_len = 0; w_cnt = 0; w_len = 0;
    r_idx = '0; w_idx = '0;
    bus.m_axi_arready = 0; bus.m_axi_awready = 0; bus.m_axi_wready = 1;
    bus.m_axi_rvalid = 0; bus.m_axi_rdata = '0; bus.m_axi_rlast = 0; bus.m_axi_rresp = '0;
    bus.m_axi_bvalid = 0; bus.m_axi_bresp = '0;
    bus.wr_valid = 0; bus.wr_data = '0; bus.wr_strb = '0;
    bus.rd_ready = 1; bus.sts_ready = 0;
    forever begin
      @(negedge clk);
      f_ar = bus.m_axi_arvalid && bus.m_axi_arready;
      f_aw = bus.m_axi_awvalid && bus.m_axi_awready;
      f_r  = bus.m_axi_rvalid && bus.m_axi_rready;
      f_w  = bus.m_axi_wvalid && bus.m_axi_wready;
      f_b  = bus.m_axi_bvalid && bus.m_axi_bready;
      f_wr = bus.wr_valid && bus.wr_ready;
      f_wdata = bus.m_axi_wdata; f_wstrb = bus.m_axi_wstrb;
      f_araddr = bus.m_axi_araddr; f_arlen = bus.m_axi_arlen;
      f_awaddr = bus.m_axi_awaddr; f_awlen = bus.m_axi_awlen;
      f_rlast = bus.m_axi_rlast;
      if (f_w) chk("w_after_aw", aw_done, 1);
      @(posedge clk);
      #1;
      if (rst) begin
        r_act = 0; aw_done = 0; b_pend = 0; wq.delete();
        bus.m_axi_arready = 0; bus.m_axi_awready = 0; bus.m_axi_rvalid = 0;
        bus.m_axi_bvalid = 0; bus.wr_valid = 0; bus.sts_ready = 0; bus.rd_ready = 1;
        continue;
      end
      if (f_ar) begin
        r_act = 1; r_beat = 0; r_idx = f_araddr[11:2]; r_len = int'(f_arlen); addr_fires++;
      end
      if (f_r) begin
        if (f_rlast) r_act = 0;
        r_beat++;
      end
      if (f_aw) begin
        aw_done = 1; w_cnt = 0; w_idx = f_awaddr[11:2]; w_len = int'(f_awlen); addr_fires++;
      end
      if (f_w) begin
        for (int b = 0; b < 4; b++)
          if (f_wstrb[b]) mem[int'(w_idx) + w_cnt][8*b +: 8] = f_wdata[8*b +: 8];
        w_cnt++; w_accepted++;
        if (w_cnt == w_len + 1) begin aw_done = 0; b_pend = 1; end
      end
      if (f_b) b_pend = 0;
      if (f_wr && wq.size() > 0) void'(wq.pop_front());

      bus.m_axi_arready = bus.m_axi_arvalid && !bus.m_axi_arready;
      bus.m_axi_awready = bus.m_axi_awvalid && !bus.m_axi_awready;
      bus.m_axi_rvalid  = r_act;
      bus.m_axi_rdata   = r_act ? mem[(int'(r_idx) + r_beat) % 1024] : 32'h0;
      bus.m_axi_rlast   = r_act && (r_beat == ((k_rlast_beat < 0) ? r_len : k_rlast_beat));
      bus.m_axi_rresp   = (r_act && r_beat == k_rerr_beat) ? 2'b10 : 2'b00;
      bus.m_axi_bvalid  = b_pend;
      bus.m_axi_bresp   = k_bresp;
      bus.wr_valid      = (wq.size() > 0);
      bus.wr_data       = (wq.size() > 0) ? wq[0].d : 32'h0;
      bus.wr_strb       = (wq.size() > 0) ? wq[0].s : 4'h0;
      bus.sts_ready     = bus.sts_valid && !bus.sts_ready;
      bus.rd_ready      = k_toggle ? !bus.rd_ready : 1'b1;
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare
    rexp_t e;
    logic [2:0] s;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (bus.m_axi_rvalid) begin
        chk("rready_mirror", bus.m_axi_rready, bus.rd_ready);
        chk("rd_valid_pass", bus.rd_valid, 1);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        rd_log.push_back(bus.rd_data);
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = exp_rd.pop_front();
          chk("rd_data", bus.rd_data, e.d);
          chk("rd_last", bus.rd_last, e.l);
        end
      end
      if (bus.sts_valid && bus.sts_ready) begin
        last_code = bus.sts_code; last_err = bus.sts_err; sts_seen++;
        if (exp_sts.size() == 0) chk("sts_unexpected", 1, 0);
        else begin
          s = exp_sts.pop_front();
          chk("sts_err", bus.sts_err, s[2]);
          chk("sts_code", bus.sts_code, s[1:0]);
        end
      end
      if (bus.m_axi_arvalid) begin
        chk("ar_on_illegal", cur_illegal, 0);
        chk("ar_addr", bus.m_axi_araddr, cur_addr);
        chk("ar_len", bus.m_axi_arlen, cur_len);
        chk("ar_size", bus.m_axi_arsize, 3'b010);
        chk("ar_burst", bus.m_axi_arburst, 2'b01);
      end
      if (bus.m_axi_awvalid) begin
        chk("aw_on_illegal", cur_illegal, 0);
        chk("aw_addr", bus.m_axi_awaddr, cur_addr);
        chk("aw_len", bus.m_axi_awlen, cur_len);
        chk("aw_size", bus.m_axi_awsize, 3'b010);
        chk("aw_burst", bus.m_axi_awburst, 2'b01);
      end
    end
  end

  // ---------------- reference model and command driver ----------------
  task automatic push_wr(input logic [31:0] addr, input int k, input logic [31:0] d,
                         input logic [3:0] s, input logic upd);
    int idx;
    wq.push_back('{d: d, s: s});
    idx = (int'(addr[11:2]) + k) % 1024;
    if (upd)
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    int  page_end, last_b, base;
    logic legal;
    logic [1:0] code;
    page_end = int'(addr % 4096) + 4 * (int'(len) + 1);
    legal = (addr % 4 == 0) && (int'(len) <= 15) && (page_end <= 4096);
    cur_illegal = !legal; cur_addr = addr; cur_len = len;
    if (!legal) begin
      exp_sts.push_back({1'b1, STS_ILLEGAL});
    end else if (wr) begin
      code = (k_bresp != 2'b00) ? STS_SLVERR : STS_OK;
      exp_sts.push_back({code != STS_OK, code});
    end else begin
      last_b = (k_rlast_beat < 0) ? int'(len) : k_rlast_beat;
      base = int'(addr[11:2]);
      for (int k = 0; k <= last_b; k++)
        exp_rd.push_back('{d: model_mem[(base + k) % 1024], l: (k == last_b)});
      if (k_rerr_beat >= 0 && k_rerr_beat <= last_b) code = STS_SLVERR;
      else if (last_b != int'(len))                  code = STS_LASTERR;
      else                                           code = STS_OK;
      exp_sts.push_back({code != STS_OK, code});
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_len = len;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      if (t == 199) chk("cmd_accept_timeout", 0, 1);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 0;
  endtask

  task automatic wait_sts(input int target);
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      if (sts_seen >= target) return;
    end
    chk("sts_timeout", sts_seen, target);
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    int target;
    target = sts_seen + 1;
    send_cmd(wr, addr, len);
    wait_sts(target);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
    chk({tag, "_wr_ready"},  bus.wr_ready, 0);
    chk({tag, "_rd_valid"},  bus.rd_valid, 0);
    chk({tag, "_sts_valid"}, bus.sts_valid, 0);
    chk({tag, "_sts_code"},  {bus.sts_err, bus.sts_code}, 0);
    chk({tag, "_awvalid"},   bus.m_axi_awvalid, 0);
    chk({tag, "_wvalid"},    bus.m_axi_wvalid, 0);
    chk({tag, "_bready"},    bus.m_axi_bready, 0);
    chk({tag, "_arvalid"},   bus.m_axi_arvalid, 0);
    chk({tag, "_rready"},    bus.m_axi_rready, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0, base, target;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h1000_0000 + i;
      model_mem[i] = 32'h1000_0000 + i;
    end
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 0;
    @(negedge clk);
    chk("idle_cmd_ready", bus.cmd_ready, 1);

    // Write then read back the same burst.
    for (int k = 0; k < 4; k++) push_wr(32'h100, k, 32'hA0 + k, 4'hF, 1);
    run_cmd(1, 32'h100, 8'd3);
    chk("wr1_code", last_code, 0);
    rd_log.delete();
    run_cmd(0, 32'h100, 8'd3);
    chk("rd1_count", rd_log.size(), 4);
    chk("rd1_beat0", rd_log[0], 32'hA0);
    chk("rd1_beat3", rd_log[3], 32'hA3);

    // Partial strobes, then a len-7 read under toggling rd_ready.
    for (int k = 0; k < 8; k++)
      push_wr(32'h300, k, 32'hC0DE_0000 + k, (k == 2) ? 4'b0011 : 4'hF, 1);
    run_cmd(1, 32'h300, 8'd7);
    k_toggle = 1; rd_log.delete();
    run_cmd(0, 32'h300, 8'd7);
    k_toggle = 0;
    chk("rd8_count", rd_log.size(), 8);
    chk("rd8_strb_merge", rd_log[2], 32'h10000_0C2 - 32'h10000_0C2 + 32'h1000_0002 & 32'hFFFF_0000 | 32'h0000_0002);

    // Illegal commands never reach AXI.
    n0 = addr_fires;
    run_cmd(1, 32'hFF8, 8'd3);
    chk("ill_page_code", last_code, 3);
    chk("ill_page_err", last_err, 1);
    run_cmd(0, 32'h102, 8'd0);
    chk("ill_align_code", last_code, 3);
    run_cmd(0, 32'h0, 8'd16);
    chk("ill_len_code", last_code, 3);
    chk("ill_no_axi", addr_fires, n0);
    run_cmd(0, 32'hFF0, 8'd3);
    chk("page_edge_ok", last_code, 0);

    // Slave error responses.
    k_bresp = 2'b10;
    push_wr(32'h400, 0, 32'h5555_AAAA, 4'hF, 1);
    run_cmd(1, 32'h400, 8'd0);
    k_bresp = 2'b00;
    chk("bresp_code", last_code, 1);
    k_rerr_beat = 1; rd_log.delete();
    run_cmd(0, 32'h100, 8'd3);
    k_rerr_beat = -1;
    chk("rresp_beats", rd_log.size(), 4);
    chk("rresp_code", last_code, 1);

    // Early rlast.
    k_rlast_beat = 2; rd_log.delete();
    run_cmd(0, 32'h100, 8'd3);
    k_rlast_beat = -1;
    chk("rlast_beats", rd_log.size(), 3);
    chk("rlast_code", last_code, 2);

    // Asynchronous reset in the middle of a write burst.
    for (int k = 0; k < 4; k++) push_wr(32'h200, k, 32'hDEAD_0000 + k, 4'hF, 0);
    base = w_accepted;
    send_cmd(1, 32'h200, 8'd3);
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      if (w_accepted >= base + 2) break;
      if (t == 199) chk("w_progress_timeout", w_accepted, base + 2);
    end
    #3 rst = 1;
    #1 chk_quiet("midburst");
    exp_sts.delete(); exp_rd.delete(); wq.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    target = sts_seen + 1;
    rd_log.delete();
    send_cmd(0, 32'h100, 8'd3);
    wait_sts(target);
    chk("post_rst_code", last_code, 0);
    chk("post_rst_beat1", rd_log[1], 32'hA1);

    repeat (3) @(posedge clk);
    chk("exp_rd_drained", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 initiator that turns one command into one INCR burst, read or write, on a 32-bit AXI4 port.
- Acts as the counterpart of the simulation memory responder.
- Used as a DMA/traffic-generator front end and as a bench driver for memory responders.
- Write data enters on a valid/ready stream, read data leaves on a valid/ready stream, and one completion status is returned per command.

Parameters:
- ADDR_W, 32, address width.
- MAX_LEN, 15, largest legal cmd_len (AXI len encoding; beats = len+1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both valid and ready are high
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  byte address of the first beat
- cmd_len  in  8  beats minus one
- wr_valid/wr_ready  in/out  1  write-data stream handshake
- wr_data  in  32  write data
- wr_strb  in  4  write byte strobes
- rd_valid/rd_ready  out/in  1  read-data stream handshake
- rd_data  out  32  read data
- rd_last  out  1  final read beat
- sts_valid/sts_ready  out/in  1  completion status handshake
- sts_err  out  1  slave error or protocol error
- sts_code  out  2  0 ok, 1 slave resp, 2 rlast mismatch, 3 illegal command
- m_axi_aw{valid,ready,addr,len,size,burst}  AXI4 write-address channel (valid/addr/len/size/burst out, ready in)
- m_axi_w{valid,ready,data,strb}  AXI4 write-data channel; no wlast port, the write burst length is implied by awlen
- m_axi_b{valid,ready,resp}  AXI4 write-response channel (valid/resp in, ready out)
- m_axi_ar{valid,ready,addr,len,size,burst}  AXI4 read-address channel (valid/addr/len/size/burst out, ready in)
- m_axi_r{valid,ready,last,data,resp}  AXI4 read-data channel (valid/last/data/resp in, ready out)

Behaviour:
- Fixed output fields: size = 3'b010 and burst = 2'b01 on both AW and AR.
- Reset values: all valid/ready outputs 0, sts fields 0, state IDLE. Reset mid-burst abandons the transaction immediately; nothing is replayed.
- State machine: IDLE, CHK, AR, R, AW, W, B, STS.
- IDLE: cmd_ready = 1. On handshake, latch write/addr/len and go to CHK. cmd_ready is 0 in every other state.
- CHK (1 cycle) marks the command illegal if any of the following holds:
  - addr[1:0] != 0
  - len > MAX_LEN
  - the burst crosses a 4 KB page, i.e. addr[11:0] + 4*(len+1) > 4096
- Illegal command: go to STS with code 3. No AXI traffic is issued.
- Legal command: go to AR (read) or AW (write).
- AR: arvalid held with stable addr/len until arready, then go to R. AR valid is never dropped before arready.
- R:
  - rready = rd_ready; rd_valid = rvalid; rd_data/rd_last pass combinationally from the R channel. rd_last = rlast.
  - Zero added latency; backpressure propagates directly.
  - Beat counter counts accepted beats.
  - The burst ends at the first accepted beat with rlast = 1, then go to STS.
  - rlast on a beat other than beat len, or beat len accepted without rlast: code 2, sticky. Keep accepting beats until rlast.
  - Any rresp != 0: code 1, sticky. Code 1 takes priority over code 2.
- AW: awvalid held until awready, then go to W. Write data is never issued before AW completes.
- W:
  - wvalid = wr_valid, wr_ready = wready, data/strb pass through.
  - After len+1 accepted beats, go to B. wr_ready = 0 outside W.
- B: bready = 1. On bvalid: bresp != 0 gives code 1. Go to STS.
- STS:
  - sts_valid held with stable err/code until sts_ready, then go to IDLE.
  - sts_err = (code != 0).
  - A new command cannot be accepted in the same cycle as the status handshake.
- Counters: beat counter is 9 bits, so len = 255 cannot wrap, and it clears on entry to R/W.
- Simultaneous events: AR/AW is the only outstanding request; there is no overlap between commands.
- Unexpected inputs: bvalid or rvalid arriving in a non-owning state is ignored, because the matching ready is 0.

Decomposition:
- Package axi_burst_pkg holds:
  - state enum
  - AXI_SIZE_4B and AXI_BURST_INCR constants
  - status code constants STS_OK, STS_SLVERR, STS_LASTERR, STS_ILLEGAL
- No sub-module is required; channel muxing is inline. Optionally a small axi_burst_chk combinational legality checker.

Test Plan:
- Write cmd addr 0x100, len 3, data 0xA0..0xA3, strb 0xF, against the memory responder → one AW with awlen 3, four W beats, sts ok. A following read of 0x100, len 3 returns 0xA0..0xA3 with rd_last on beat 4.
- Read len 7 with rd_ready toggling every other cycle → 8 beats delivered in order, no beat lost or duplicated, rready mirrors rd_ready.
- cmd_addr 0xFF8, len 3 (crosses 4 KB) → no AWVALID/ARVALID ever asserted, sts_err 1, code 3. cmd_addr 0x102 → code 3.
- Responder returns bresp 2'b10 → sts_err 1, code 1. Read with rresp 2'b10 on beat 1 of 4 → all 4 beats delivered, code 1.
- Responder asserts rlast on beat 2 of len 3 → burst ends after 3 beats, code 2.
- rst_i asserted during W beat 2 → all valid/ready outputs 0 within the same cycle (async). After release, cmd_ready = 1 and a new read completes ok.
